// File: rtl/dma_desc_fetcher.sv
// Descriptor-chain fetcher: reads 5-word descriptors over AXI AR/R and feeds them
// field by field to the DMA register block, then waits for EOT and follows the chain.
module dma_desc_fetcher #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] desc_base,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [LEN_W-1:0]  ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [DATA_W-1:0] DESC_input,
    output logic [3:0]        sel,
    output logic              isTransferring,
    input  logic              EOT,
    output logic              busy,
    output logic              chain_done,
    output logic              desc_err
);

    typedef enum logic [2:0] {IDLE, AR, RD, XFER, ERR} state_t;

    state_t            state;
    logic [2:0]        beat;
    logic [DATA_W-1:0] dma_len;
    logic [ADDR_W-1:0] next_desc;
    logic              eoc;

    logic              rbeat;
    logic              last_beat;
    logic              beat_bad;
    logic              do_chain;
    logic              chain_eoc;

    assign ARLEN   = LEN_W'(4);
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign busy    = (state != IDLE);

    // A beat is bad on a non-OKAY response or when RLAST disagrees with beat 4.
    always_comb begin
        rbeat     = RVALID && RREADY;
        last_beat = (beat == 3'd4);
        beat_bad  = (RRESP != 2'b00) || (RLAST != last_beat);
        do_chain  = 1'b0;
        chain_eoc = eoc;
        if (state == RD && rbeat && last_beat && !beat_bad && dma_len == '0) begin
            do_chain  = 1'b1;
            chain_eoc = RDATA[0];
        end else if (state == XFER && isTransferring && EOT) begin
            do_chain  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            beat           <= 3'd0;
            dma_len        <= '0;
            next_desc      <= '0;
            eoc            <= 1'b0;
            ARADDR         <= '0;
            ARVALID        <= 1'b0;
            RREADY         <= 1'b0;
            DESC_input     <= '0;
            sel            <= 4'd0;
            isTransferring <= 1'b0;
            chain_done     <= 1'b0;
            desc_err       <= 1'b0;
        end else begin
            sel        <= 4'd0;
            chain_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ARADDR   <= desc_base;
                        ARVALID  <= 1'b1;
                        desc_err <= 1'b0;
                        state    <= AR;
                    end
                end
                AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        beat    <= 3'd0;
                        state   <= RD;
                    end
                end
                RD: begin
                    if (rbeat) begin
                        if (beat_bad) begin
                            desc_err <= 1'b1;
                            if (RLAST) begin
                                RREADY <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                state  <= ERR;
                            end
                        end else begin
                            sel        <= {1'b0, beat} + 4'd1;
                            DESC_input <= RDATA;
                            beat       <= beat + 3'd1;
                            case (beat)
                                3'd2:    dma_len   <= RDATA;
                                3'd3:    next_desc <= ADDR_W'(RDATA);
                                3'd4:    eoc       <= RDATA[0];
                                default: ;
                            endcase
                            // Zero-length descriptors skip XFER; do_chain handles them below.
                            if (last_beat) begin
                                RREADY <= 1'b0;
                                if (dma_len != '0)
                                    state <= XFER;
                            end
                        end
                    end
                end
                XFER: begin
                    // First XFER cycle carries the sel=5 write, so the transfer starts one cycle later.
                    if (!isTransferring)
                        isTransferring <= 1'b1;
                    else if (EOT)
                        isTransferring <= 1'b0;
                end
                ERR: begin
                    if (rbeat && RLAST) begin
                        RREADY <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (do_chain) begin
                if (chain_eoc) begin
                    chain_done <= 1'b1;
                    state      <= IDLE;
                end else if (next_desc[1:0] != 2'b00) begin
                    desc_err   <= 1'b1;
                    state      <= IDLE;
                end else begin
                    ARADDR     <= next_desc;
                    ARVALID    <= 1'b1;
                    state      <= AR;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_desc_fetcher.sv
// Bench for dma_desc_fetcher: AXI slave + DMA EOT model, chain-walking reference
// model feeding expectation queues, and a negedge monitor that pops and compares.
module tb_dma_desc_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] desc_base = '0;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0;
    logic        RLAST = 1'b0;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic [31:0] DESC_input;
    logic [3:0]  sel;
    logic        isTransferring;
    logic        EOT = 1'b0;
    logic        busy;
    logic        chain_done;
    logic        desc_err;

    dma_desc_fetcher #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .desc_base(desc_base),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .DESC_input(DESC_input), .sel(sel), .isTransferring(isTransferring), .EOT(EOT),
        .busy(busy), .chain_done(chain_done), .desc_err(desc_err)
    );

    always #5 clk = ~clk;

    // Memory image and per-descriptor fault injection:
    // kind 1 = RRESP error on beat fbeat, 2 = early RLAST on beat fbeat, 3 = no RLAST on beat 4.
    logic [31:0] mem   [logic [31:0]];
    int          fkind [logic [31:0]];
    int          fbeat [logic [31:0]];
    int          ar_delay = 0;
    int          gap_mode = 0;

    typedef struct packed {
        logic [3:0]  s;
        logic [31:0] d;
    } fld_t;

    logic [31:0] exp_ar[$];
    fld_t        exp_fld[$];
    int          exp_done = 0;
    int          exp_xfer = 0;
    int          xfer_seen = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic int kind_of(input logic [31:0] a);
        return fkind.exists(a) ? fkind[a] : 0;
    endfunction

    function automatic int beat_of(input logic [31:0] a);
        return fbeat.exists(a) ? fbeat[a] : 0;
    endfunction

    task automatic clear_cfg();
        mem.delete();
        fkind.delete();
        fbeat.delete();
        ar_delay = 0;
        gap_mode = 0;
    endtask

    task automatic write_desc(input logic [31:0] a, input logic [31:0] src, input logic [31:0] dst,
                              input logic [31:0] len, input logic [31:0] nxt, input logic [31:0] eocw);
        mem[a]      = src;
        mem[a + 4]  = dst;
        mem[a + 8]  = len;
        mem[a + 12] = nxt;
        mem[a + 16] = eocw;
    endtask

    // Walks the descriptor chain in memory and lists what the DMA side must observe.
    task automatic expect_chain(input logic [31:0] base, output bit err);
        logic [31:0] a;
        logic [31:0] w;
        int          k;
        int          nf;
        fld_t        f;
        a   = base;
        err = 1'b0;
        for (int hop = 0; hop < 8; hop++) begin
            exp_ar.push_back(a);
            k  = kind_of(a);
            nf = (k == 0) ? 5 : (k == 3) ? 4 : beat_of(a);
            for (int i = 0; i < nf; i++) begin
                f.s = 4'(i + 1);
                f.d = rd_word(a + 32'(4 * i));
                exp_fld.push_back(f);
            end
            if (k != 0) begin
                err = 1'b1;
                return;
            end
            if (rd_word(a + 8) != 32'h0)
                exp_xfer++;
            w = rd_word(a + 16);
            if (w[0]) begin
                exp_done++;
                return;
            end
            w = rd_word(a + 12);
            if (w[1:0] != 2'b00) begin
                err = 1'b1;
                return;
            end
            a = w;
        end
    endtask

    // AXI read slave: inputs change 1 time unit after the rising edge.
    initial begin : slave
        int          phase;
        int          bi;
        int          ar_wait;
        int          k;
        int          lastb;
        bit          ar_armed;
        bit          gap_tog;
        bit          ar_hs;
        bit          r_hs;
        logic [31:0] cap_addr;
        logic [31:0] rd_addr;
        phase = 0; bi = 0; ar_wait = 0; ar_armed = 1'b0; gap_tog = 1'b0; rd_addr = '0;
        forever begin
            @(posedge clk);
            ar_hs    = ARVALID && ARREADY;
            r_hs     = RVALID && RREADY;
            cap_addr = ARADDR;
            #1;
            if (!rst) begin
                phase = 0; ar_armed = 1'b0;
                ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
            end else begin
                if (phase == 1 && r_hs) begin
                    if (RLAST) phase = 0;
                    else bi++;
                end else if (phase == 0 && ar_hs) begin
                    phase = 1; bi = 0; rd_addr = cap_addr; ar_armed = 1'b0;
                end
                if (phase == 0) begin
                    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
                    if (ARVALID) begin
                        if (!ar_armed) begin
                            ar_wait  = ar_delay;
                            ar_armed = 1'b1;
                        end
                        ARREADY = (ar_wait == 0);
                        if (ar_wait > 0) ar_wait--;
                    end else begin
                        ARREADY = 1'b0;
                    end
                end else begin
                    ARREADY = 1'b0;
                    k     = kind_of(rd_addr);
                    lastb = (k == 2) ? beat_of(rd_addr) : (k == 3) ? 5 : 4;
                    case (gap_mode)
                        0: RVALID = 1'b1;
                        1: begin RVALID = gap_tog; gap_tog = !gap_tog; end
                        default: RVALID = 1'($urandom_range(0, 1));
                    endcase
                    RDATA = rd_word(rd_addr + 32'(4 * bi));
                    RRESP = (k == 1 && bi == beat_of(rd_addr)) ? 2'b10 : 2'b00;
                    RLAST = (bi == lastb);
                end
            end
        end
    end

    // DMA model: EOT some cycles into each transfer, plus stray EOT pulses while idle.
    initial begin : dma
        int w;
        w = -1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                EOT = 1'b0; w = -1;
            end else if (EOT) begin
                EOT = 1'b0;
            end else if (isTransferring) begin
                if (w < 0) w = $urandom_range(0, 4);
                if (w == 0) begin EOT = 1'b1; w = -1; end
                else w--;
            end else if (sel != 4'd5 && $urandom_range(0, 7) == 0) begin
                EOT = 1'b1;
            end
        end
    end

    initial begin : monitor
        logic [3:0]  psel;
        bit          pxfer;
        bit          parv;
        bit          parr;
        logic [31:0] paddr;
        logic [31:0] a;
        fld_t        f;
        psel = '0; pxfer = 1'b0; parv = 1'b0; parr = 1'b0; paddr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                psel = '0; pxfer = 1'b0; parv = 1'b0; parr = 1'b0;
            end else begin
                if (parv && !parr) begin
                    check("arvalid_held", ARVALID, 1);
                    check("araddr_held", ARADDR, paddr);
                end
                if (ARVALID && ARREADY) begin
                    check("ar_expected", exp_ar.size() > 0, 1);
                    if (exp_ar.size() > 0) begin
                        a = exp_ar.pop_front();
                        check("araddr", ARADDR, a);
                    end
                    check("arlen", ARLEN, 4);
                    check("arsize", ARSIZE, 2);
                    check("arburst", ARBURST, 1);
                end
                if (sel != 4'd0) begin
                    check("field_expected", exp_fld.size() > 0, 1);
                    if (exp_fld.size() > 0) begin
                        f = exp_fld.pop_front();
                        check("sel", sel, f.s);
                        check("desc_input", DESC_input, f.d);
                    end
                end
                if (chain_done) begin
                    check("chain_done_expected", exp_done > 0, 1);
                    if (exp_done > 0) exp_done--;
                end
                if (isTransferring) begin
                    check("sel_quiet_in_xfer", sel, 0);
                    if (!pxfer) begin
                        xfer_seen++;
                        check("xfer_follows_sel5", psel, 5);
                    end
                end
                psel = sel; pxfer = isTransferring; parv = ARVALID; parr = ARREADY; paddr = ARADDR;
            end
        end
    end

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic run_chain(input logic [31:0] base, input bit poke);
        bit ee;
        int cyc;
        xfer_seen = 0;
        exp_xfer  = 0;
        exp_done  = 0;
        expect_chain(base, ee);
        start     = 1'b1;
        desc_base = base;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("desc_err_cleared", desc_err, 0);
        check("busy_after_start", busy, 1);
        cyc = 0;
        while (busy && cyc < 3000) begin
            if (poke && cyc == 2) begin
                start     = 1'b1;
                desc_base = 32'hDEAD_0000;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check("chain_finished", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check("desc_err", desc_err, ee);
        check("ar_left", exp_ar.size(), 0);
        check("fields_left", exp_fld.size(), 0);
        check("chain_done_left", exp_done, 0);
        check("xfer_count", xfer_seen, exp_xfer);
        exp_ar.delete();
        exp_fld.delete();
        exp_done = 0;
    endtask

    task automatic mid_reset(input bit in_xfer);
        bit ee;
        int cyc;
        clear_cfg();
        write_desc(32'h400, 32'hA0, 32'hB0, 32'h10, 32'h0, 32'h1);
        xfer_seen = 0; exp_xfer = 0; exp_done = 0;
        expect_chain(32'h400, ee);
        start     = 1'b1;
        desc_base = 32'h400;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!(in_xfer ? isTransferring : (sel != 4'd0)) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reset_point_reached", in_xfer ? isTransferring : (sel != 4'd0), 1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_addr_data", {ARADDR, DESC_input}, 0);
        check("rst_async_ctrl", {ARVALID, RREADY, sel, isTransferring, busy, chain_done, desc_err}, 0);
        exp_ar.delete();
        exp_fld.delete();
        exp_done = 0; exp_xfer = 0; xfer_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_chain(32'h400, 1'b0);
    endtask

    task automatic random_chain(output logic [31:0] base);
        logic [31:0] a [4];
        logic [31:0] nx;
        logic [31:0] r;
        logic [31:0] len;
        bit          eo;
        int          n;
        int          i;
        int          k;
        clear_cfg();
        n = $urandom_range(1, 4);
        for (int j = 0; j < 4; j++)
            a[j] = 32'h8000 + 32'(j * 256) + 32'($urandom_range(0, 48) * 4);
        for (int j = 0; j < n; j++) begin
            eo = (j == n - 1);
            nx = eo ? $urandom : a[(j + 1) % 4];
            if (eo && $urandom_range(0, 7) == 0) begin
                eo = 1'b0;
                r  = $urandom;
                nx = r | 32'h2;
            end
            len = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 255));
            r   = $urandom;
            write_desc(a[j], $urandom, $urandom, len, nx, {r[31:1], eo});
        end
        if ($urandom_range(0, 5) == 0) begin
            i = $urandom_range(0, n - 1);
            k = $urandom_range(1, 3);
            fkind[a[i]] = k;
            fbeat[a[i]] = (k == 1) ? $urandom_range(0, 4) : (k == 2) ? $urandom_range(0, 3) : 4;
        end
        ar_delay = $urandom_range(0, 3);
        gap_mode = $urandom_range(0, 2);
        base = a[0];
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] base;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr_data", {ARADDR, DESC_input}, 0);
        check("rst_ctrl", {ARVALID, RREADY, sel, isTransferring, busy, chain_done, desc_err}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_release", busy, 0);

        clear_cfg();
        write_desc(32'h100, 32'h1000, 32'h2000, 32'h40, 32'h0, 32'h1);
        run_chain(32'h100, 1'b0);

        clear_cfg();
        write_desc(32'h100, 32'h1000, 32'h2000, 32'h40, 32'h200, 32'h0);
        write_desc(32'h200, 32'h3000, 32'h4000, 32'h80, 32'h0, 32'h1);
        run_chain(32'h100, 1'b1);

        ar_delay = 3;
        gap_mode = 1;
        run_chain(32'h100, 1'b0);
        ar_delay = 0;
        gap_mode = 0;

        fkind[32'h100] = 1;
        fbeat[32'h100] = 2;
        run_chain(32'h100, 1'b0);
        fkind.delete();
        fbeat.delete();
        run_chain(32'h100, 1'b0);

        clear_cfg();
        write_desc(32'h500, 32'h1, 32'h2, 32'h0, 32'h0, 32'h1);
        run_chain(32'h500, 1'b0);

        clear_cfg();
        write_desc(32'h500, 32'h1, 32'h2, 32'h5, 32'h0, 32'h1);
        fkind[32'h500] = 2;
        fbeat[32'h500] = 3;
        run_chain(32'h500, 1'b0);
        fkind[32'h500] = 3;
        fbeat[32'h500] = 4;
        run_chain(32'h500, 1'b0);

        clear_cfg();
        write_desc(32'h600, 32'h11, 32'h22, 32'h8, 32'h702, 32'h0);
        run_chain(32'h600, 1'b0);

        mid_reset(1'b1);
        mid_reset(1'b0);

        for (int n = 0; n < 40; n++) begin
            random_chain(base);
            run_chain(base, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_desc_fetcher.md
Name: dma_desc_fetcher

Overview:
- Master-side companion to the descriptor-based DMA register block. It reads descriptor chains from memory over an AXI read channel and drives the DMA's DESC_input/sel write interface, one field per cycle.
- After each descriptor is loaded, it holds isTransferring until the DMA reports EOT. It then follows NEXT_DESC until a descriptor with EOC set completes.
- Sits between the DMA register block and the AXI interconnect, as an AR/R-only master.

Parameters:
ADDR_W, 32, address width (matches `AXI_ADDR_BITS)
DATA_W, 32, data width (matches `AXI_DATA_BITS)
LEN_W, 4, burst length width (matches `AXI_LEN_BITS)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  1-cycle pulse; begin a chain at desc_base; ignored unless IDLE
desc_base  in  ADDR_W  address of first descriptor, sampled with start
ARADDR  out  ADDR_W  descriptor address
ARLEN  out  LEN_W  fixed 4 (5 beats)
ARSIZE  out  3  fixed 3'b010
ARBURST  out  2  fixed 2'b01 (INCR)
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
RDATA  in  DATA_W  read data
RRESP  in  2  read response
RLAST  in  1  last beat
RVALID  in  1  read data valid
RREADY  out  1  read data ready
DESC_input  out  DATA_W  descriptor field to the DMA
sel  out  4  field select: 0 none, 1 DMASRC, 2 DMADST, 3 DMALEN, 4 NEXT_DESC, 5 EOC
isTransferring  out  1  DMA transfer phase active
EOT  in  1  end of transfer from the DMA, sampled only in XFER
busy  out  1  state != IDLE
chain_done  out  1  1-cycle pulse when the EOC descriptor finishes
desc_err  out  1  sticky error flag, cleared by the next accepted start

Behaviour:
- Reset values: all outputs 0, state IDLE, internal beat counter 0, latched DMALEN/NEXT_DESC/EOC 0.
- States: IDLE, AR, RD, XFER, ERR.
- IDLE:
  - start=1: latch desc_base into ARADDR, clear desc_err, go to AR on the next edge.
  - start in any other state is ignored.
- AR:
  - ARVALID=1, ARADDR stable until ARREADY=1.
  - On the handshake: ARVALID drops next cycle, go to RD, beat counter=0.
- RD:
  - RREADY=1 throughout.
  - Each accepted beat k (RVALID&RREADY), registered into the next cycle: sel=k+1, DESC_input=RDATA. sel returns to 0 on any cycle without a beat.
  - Beat 2 also latches DMALEN, beat 3 latches NEXT_DESC, beat 4 latches EOC=RDATA[0].
- RD error checks:
  - RRESP!=0 on any beat: desc_err=1, go to ERR; remaining beats are drained with sel=0.
  - RLAST=1 on beats 0..3, or RLAST=0 on beat 4: same error handling.
  - ERR waits for the beat with RLAST (or, if RLAST came early, for that beat), then returns to IDLE. isTransferring is never asserted for a bad descriptor.
- RD exit after a good beat 4:
  - DMALEN!=0: go to XFER. isTransferring=1 starts on the cycle after the final sel=5 write is presented, so the DMA sees every field while isTransferring=0.
  - DMALEN==0: skip XFER and apply the chain decision immediately.
- XFER:
  - isTransferring=1 until EOT=1 is sampled; deasserts on the next edge.
  - Chain decision: EOC=1 → chain_done pulse, go to IDLE. EOC=0 → ARADDR=NEXT_DESC, go to AR.
- NEXT_DESC alignment: NEXT_DESC with bits[1:0]!=0 is an error; set desc_err, go to IDLE with no fetch.
- EOT outside XFER is ignored.
- Throughput: a zero-wait-state chain hop costs 1 AR cycle, 5 RD cycles, and 1 cycle from the last field to isTransferring.
- Mid-operation reset: everything returns to reset values immediately. Outstanding AXI beats are not drained; the interconnect is reset together with this block.

Test Plan:
1. Single descriptor at 0x100: {0x1000, 0x2000, 0x40, 0x0, 0x1}, zero-wait slave → ARADDR=0x100, ARLEN=4; sel sequence 1,2,3,4,5 with matching data; isTransferring high until EOT; chain_done one cycle; busy=0 afterwards.
2. Two-descriptor chain: 0x100 (NEXT_DESC=0x200, EOC=0), then 0x200 (EOC=1) → second AR at 0x200 only after the first EOT; exactly one chain_done.
3. Backpressure: ARREADY held low 3 cycles, RVALID gapped every other cycle → ARVALID/ARADDR stable; sel=0 on gap cycles; field order unchanged.
4. RRESP=2'b10 on beat 2 → desc_err=1, no isTransferring, remaining beats drained, IDLE; the next start clears desc_err.
5. DMALEN=0 with EOC=1 → isTransferring never asserts; chain_done on the cycle after beat 4 is presented. Early RLAST on beat 3 → desc_err=1.
6. Reset (rst=0) asserted during XFER, and separately during RD → all outputs 0 asynchronously; a new start after release fetches normally.
